// File: rtl/rx_gate_sequencer.sv
// Receive gate sequencer: synchronises an external trigger and opens delayed,
// width-limited gate windows for up to NCHAN rx channels, with a legacy passthrough mode.
module rx_gate_sequencer #(
  parameter int NCHAN       = 4,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trig_in,
  input  logic [1:0]       mode,
  input  logic             arm,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [15:0]      count,
  input  logic [NCHAN-1:0] chan_mask,
  input  logic             clear_status,
  output logic [NCHAN-1:0] gate_out,
  output logic             window_start,
  output logic             window_end,
  output logic [15:0]      window_idx,
  output logic             busy,
  output logic             missed_trig
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_OPEN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_q;
  logic                   trig_s;
  logic                   trig_rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [15:0]      count_q, count_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      idx_q, idx_d;
  logic             missed_q, missed_d;
  logic [NCHAN-1:0] gate_q, gate_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;

  logic             seq_mode;
  logic             abort;
  logic [15:0]      idx_inc;

  assign trig_s    = sync_q[SYNC_STAGES-1];
  assign trig_rise = trig_s & ~trig_q;

  // Trigger synchroniser chain plus one flop for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      trig_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      trig_q <= trig_s;
    end
  end

  // State, shadow configuration and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      delay_q  <= CNT_ZERO;
      width_q  <= CNT_ONE;
      count_q  <= 16'd0;
      mask_q   <= {NCHAN{1'b0}};
      mode_q   <= 2'd0;
      idx_q    <= 16'd0;
      missed_q <= 1'b0;
      gate_q   <= {NCHAN{1'b0}};
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      missed_q <= missed_d;
      gate_q   <= gate_d;
      start_q  <= start_d;
      end_q    <= end_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, counters, sticky status and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    width_d  = width_q;
    count_d  = count_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    missed_d = missed_q;
    gate_d   = {NCHAN{1'b0}};
    start_d  = 1'b0;
    end_d    = 1'b0;
    busy_d   = 1'b0;
    seq_mode = (mode == 2'd1) || (mode == 2'd2);
    // A mode change away from the armed mode aborts just like dropping arm.
    abort    = !arm || (mode != mode_q);
    idx_inc  = idx_q + 16'd1;

    if (!seq_mode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d = ST_ARMED;
            delay_d = delay;
            width_d = (width == CNT_ZERO) ? CNT_ONE : width;
            count_d = count;
            mask_d  = chan_mask;
            mode_d  = mode;
            idx_d   = 16'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (trig_rise) begin
            if (delay_q == CNT_ZERO) begin
              state_d = ST_OPEN;
              cnt_d   = width_q - CNT_ONE;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = delay_q - CNT_ONE;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_DELAY: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = ST_OPEN;
            cnt_d   = width_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_OPEN: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_ZERO) begin
            idx_d = idx_inc;
            if ((mode_q == 2'd1) || ((count_q != 16'd0) && (idx_inc == count_q))) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Set has priority over clear so a same-cycle edge is never lost.
    if (trig_rise && seq_mode && (state_q != ST_ARMED)) begin
      missed_d = 1'b1;
    end else if (clear_status) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end

    if (mode == 2'd0) begin
      gate_d = {NCHAN{trig_s}} & chan_mask;
    end else if (state_d == ST_OPEN) begin
      gate_d = mask_d;
    end else begin
      gate_d = {NCHAN{1'b0}};
    end

    start_d = (state_d == ST_OPEN) && (state_q != ST_OPEN);
    end_d   = (state_d == ST_OPEN) && (cnt_d == CNT_ZERO);
    busy_d  = (state_d == ST_DELAY) || (state_d == ST_OPEN);
  end

  assign gate_out     = gate_q;
  assign window_start = start_q;
  assign window_end   = end_q;
  assign window_idx   = idx_q;
  assign busy         = busy_q;
  assign missed_trig  = missed_q;

endmodule

// File: tb/tb_rx_gate_sequencer.sv
// Directed self-checking bench for rx_gate_sequencer (default parameters).
module tb_rx_gate_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        trig_in;
  logic [1:0]  mode;
  logic        arm;
  logic [23:0] delay;
  logic [23:0] width;
  logic [15:0] count;
  logic [3:0]  chan_mask;
  logic        clear_status;
  logic [3:0]  gate_out;
  logic        window_start;
  logic        window_end;
  logic [15:0] window_idx;
  logic        busy;
  logic        missed_trig;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c0;
  int ngate, nstart, nend, nboth, first_gate, first_start;
  logic [3:0] last_gate;

  rx_gate_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .trig_in      (trig_in),
    .mode         (mode),
    .arm          (arm),
    .delay        (delay),
    .width        (width),
    .count        (count),
    .chan_mask    (chan_mask),
    .clear_status (clear_status),
    .gate_out     (gate_out),
    .window_start (window_start),
    .window_end   (window_end),
    .window_idx   (window_idx),
    .busy         (busy),
    .missed_trig  (missed_trig)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    ngate = 0; nstart = 0; nend = 0; nboth = 0;
    first_gate = -1; first_start = -1; last_gate = 4'd0;
  endtask

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (gate_out != 4'd0) begin
      if (first_gate < 0) first_gate = cyc;
      ngate++;
      last_gate = gate_out;
    end
    if (window_start) begin
      if (first_start < 0) first_start = cyc;
      nstart++;
    end
    if (window_end) nend++;
    if (window_start && window_end) nboth++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One trigger pulse: high for 3 cycles, low for the remainder of 'period'.
  task automatic pulse(input int period);
    trig_in = 1'b1;
    ticks(3);
    trig_in = 1'b0;
    ticks(period - 3);
  endtask

  task automatic disarm();
    arm = 1'b0;
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; trig_in = 1'b0; mode = 2'd0; arm = 1'b0;
    delay = 24'd0; width = 24'd0; count = 16'd0; chan_mask = 4'd0; clear_status = 1'b0;
    clr_stats();
    ticks(3);
    check_val("rst_gate", gate_out, 0);
    check_val("rst_idx", window_idx, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_missed", missed_trig, 0);
    check_val("rst_pulses", {window_start, window_end}, 0);
    reset = 1'b0;
    ticks(2);

    // Passthrough: gate follows synchronised trigger, 3 cycles late.
    mode = 2'd0; chan_mask = 4'b0101;
    ticks(2);
    clr_stats();
    c0 = cyc; trig_in = 1'b1;
    ticks(10);
    trig_in = 1'b0;
    ticks(6);
    check_val("pt_ngate", ngate, 10);
    check_val("pt_first", first_gate - c0, 3);
    check_val("pt_value", last_gate, 4'b0101);
    check_val("pt_nstart", nstart, 0);

    // One-shot: delay 5, width 8.
    mode = 2'd1; delay = 24'd5; width = 24'd8; chan_mask = 4'hF; arm = 1'b1;
    ticks(2);
    chan_mask = 4'h3; delay = 24'd1;
    clr_stats();
    c0 = cyc;
    pulse(30);
    check_val("os_ngate", ngate, 8);
    check_val("os_first", first_gate - c0, 8);
    check_val("os_value", last_gate, 4'hF);
    check_val("os_start_align", first_start - c0, 8);
    check_val("os_nstart", nstart, 1);
    check_val("os_nend", nend, 1);
    check_val("os_idx", window_idx, 1);
    check_val("os_busy_done", busy, 0);
    check_val("os_missed0", missed_trig, 0);
    pulse(20);
    check_val("os_missed1", missed_trig, 1);
    check_val("os_no_second", ngate, 8);
    disarm();
    check_val("os_cleared", missed_trig, 0);

    // Burst of three one-cycle windows, fourth edge missed.
    mode = 2'd2; count = 16'd3; delay = 24'd0; width = 24'd1; chan_mask = 4'hA; arm = 1'b1;
    ticks(2);
    clr_stats();
    for (int e = 0; e < 4; e++) pulse(20);
    check_val("b3_ngate", ngate, 3);
    check_val("b3_nboth", nboth, 3);
    check_val("b3_nstart", nstart, 3);
    check_val("b3_idx", window_idx, 3);
    check_val("b3_missed", missed_trig, 1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    tick();
    check_val("b3_clear", missed_trig, 0);
    disarm();

    // Unlimited burst: 50 windows of width 4, delay 2.
    mode = 2'd2; count = 16'd0; delay = 24'd2; width = 24'd4; chan_mask = 4'hF; arm = 1'b1;
    ticks(2);
    clr_stats();
    for (int e = 0; e < 50; e++) pulse(10);
    ticks(10);
    check_val("bu_ngate", ngate, 200);
    check_val("bu_nend", nend, 50);
    check_val("bu_idx", window_idx, 50);
    check_val("bu_missed", missed_trig, 0);
    disarm();

    // Abort by dropping arm on the third cycle of a width-10 window.
    mode = 2'd1; delay = 24'd0; width = 24'd10; chan_mask = 4'hF; arm = 1'b1;
    ticks(2);
    clr_stats();
    trig_in = 1'b1;
    ticks(3);
    trig_in = 1'b0;
    ticks(2);
    check_val("ab_gate_on", gate_out, 4'hF);
    arm = 1'b0;
    tick();
    check_val("ab_gate_off", gate_out, 0);
    check_val("ab_busy", busy, 0);
    check_val("ab_ngate", ngate, 3);
    ticks(15);
    check_val("ab_no_end", nend, 0);
    check_val("ab_idx", window_idx, 0);
    disarm();

    // Edge during a long delay is missed; original window still on schedule.
    mode = 2'd1; delay = 24'd100; width = 24'd2; arm = 1'b1;
    ticks(2);
    clr_stats();
    c0 = cyc;
    pulse(20);
    pulse(110);
    check_val("dl_missed", missed_trig, 1);
    check_val("dl_first", first_gate - c0, 103);
    check_val("dl_ngate", ngate, 2);
    check_val("dl_idx", window_idx, 1);
    disarm();

    // Asynchronous reset during DELAY clears everything without a clock edge.
    mode = 2'd1; delay = 24'd50; width = 24'd4; arm = 1'b1;
    ticks(2);
    pulse(10);
    pulse(10);
    check_val("rd_busy", busy, 1);
    check_val("rd_missed", missed_trig, 1);
    reset = 1'b1;
    #2;
    check_val("rd_busy0", busy, 0);
    check_val("rd_missed0", missed_trig, 0);
    check_val("rd_gate0", gate_out, 0);
    reset = 1'b0;
    arm = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_gate_sequencer.md
Name: rx_gate_sequencer

Overview:
- Parametrised successor to the single-bit receive gate: `io_rx_a[15]` currently drives the rx_chain resets and the FIFO gate directly.
- Synchronises an external trigger and applies a programmable delay and window width. Supports several windows per arm.
- Produces per-channel gate enables for up to NCHAN rx_chains and the rx FIFO. Sits between the daughterboard I/O pin and the rx_chain/FIFO gate inputs.
- A passthrough mode reproduces the legacy direct-gate behaviour.

Parameters:
- NCHAN, 4, number of gated rx channels (1..8)
- CNT_W, 24, width of delay/width counters in clock cycles
- SYNC_STAGES, 2, trigger synchroniser depth (>=2)

Ports:
- clock  in  1  master DSP clock (clk64 domain)
- reset  in  1  asynchronous, active-high; clears all state
- trig_in  in  1  asynchronous external trigger/gate pin
- mode  in  2  0=passthrough, 1=one-shot, 2=burst, 3=disabled
- arm  in  1  level; high arms the sequencer, low aborts/disarms
- delay  in  CNT_W  cycles from accepted trigger edge to window open
- width  in  CNT_W  window length in cycles (0 treated as 1)
- count  in  16  windows per arm in mode 2 (0 = unlimited)
- chan_mask  in  NCHAN  per-channel gate enable mask
- clear_status  in  1  synchronous clear of missed_trig
- gate_out  out  NCHAN  per-channel gate (high = channel running)
- window_start  out  1  one-cycle pulse on first gate cycle
- window_end  out  1  one-cycle pulse on last gate cycle
- window_idx  out  16  completed windows since arm
- busy  out  1  high in DELAY or OPEN
- missed_trig  out  1  sticky: trigger edge arrived while not ARMED (modes 1/2)

Behaviour:
- Reset values:
  - All outputs 0; synchroniser flops 0; state IDLE.
- Synchroniser and edge detect:
  - trig_in passes through SYNC_STAGES flops to give trig_s, then one more flop to give trig_q.
  - trig_rise = trig_s & ~trig_q. A trig_in edge therefore yields trig_rise SYNC_STAGES cycles later.
- Mode 0 (passthrough):
  - gate_out = {NCHAN{trig_s}} & chan_mask, registered: SYNC_STAGES+1 cycles after trig_in.
  - FSM held in IDLE; window pulses 0.
- Mode 3:
  - gate_out 0; FSM forced to IDLE.
- States: IDLE, ARMED, DELAY, OPEN, DONE (modes 1/2).
  - IDLE->ARMED when arm=1. On this transition:
    - latch delay, width (0->1), count, chan_mask into shadow registers;
    - clear window_idx.
  - ARMED on trig_rise:
    - delay==0 -> OPEN, with the width counter loaded;
    - else -> DELAY, with the delay counter loaded with delay-1.
  - DELAY: decrement each cycle; at 0 -> OPEN.
    - The first gate cycle occurs exactly delay+1 cycles after trig_rise.
  - OPEN: gate_out = shadow mask for exactly width cycles.
    - window_start is high on the first OPEN cycle; window_end is high on the last. Both are high in the same cycle when width=1.
  - End of OPEN:
    - window_idx increments.
    - Mode 1 -> DONE.
    - Mode 2 -> DONE if count!=0 and the new idx==count, else ARMED. There is no gap cycle; a trig_rise is accepted on the first cycle back in ARMED.
  - DONE: gate low; -> IDLE when arm=0.
- busy = state in {DELAY, OPEN}.
- gate_out is registered from the next-state decode so that it aligns with the OPEN state.
- Trigger edge while not in ARMED (IDLE, DELAY, OPEN, DONE) in modes 1/2:
  - the edge is ignored and missed_trig is set;
  - clear_status clears it, but a same-cycle set wins;
  - missed_trig is not set in modes 0/3.
- arm=0 in any state other than IDLE (abort):
  - next state IDLE; gate_out 0 on the next cycle;
  - no window_end pulse; window_idx retained until the next arm.
- Mode change while not IDLE: treated as abort (same as arm=0).
- Config inputs are ignored except at IDLE->ARMED.
- window_idx wraps 0xFFFF->0 in unlimited burst.
- Reset asserted mid-window: gate_out drops asynchronously and immediately.

Test Plan:
- Mode 0, mask=4'b0101, trig_in high for 10 cycles -> gate_out=4'b0101 for 10 cycles, starting 3 cycles after trig_in rise (SYNC_STAGES=2).
- Mode 1, delay=5, width=8, mask=4'hF, arm, one trig edge:
  - gate_out=4'hF for exactly 8 cycles, first cycle 6 cycles after trig_rise;
  - window_start and window_end single pulses; window_idx=1; state DONE.
  - A second edge sets missed_trig, with no second window.
- Mode 2, count=3, delay=0, width=1, four trigger edges spaced 20 cycles apart:
  - three one-cycle windows, each with window_start=window_end=1;
  - window_idx=3; the fourth edge sets missed_trig.
  - clear_status then clears it.
- Mode 2, count=0, delay=2, width=4, trigger edges every 10 cycles for 50 edges -> 50 windows, window_idx=50, missed_trig=0.
- Abort/reset:
  - arm dropped during OPEN at cycle 3 of width=10 -> gate_out 0 next cycle, no window_end, IDLE.
  - reset asserted during DELAY -> all outputs 0 immediately.
- Edge during DELAY (delay=100) -> missed_trig=1; the original window still opens on schedule.
